regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file, the successor to the single-write-port 32x32 regfile in the pipelined MIPS datapath.
- 2 combinational read ports and 2 write ports.
- Optional write-to-read bypass, so the ID stage sees same-cycle WB data without a separate forwarding mux.
- Optional hardwired zero register.
- Sequential clear engine: clears one entry per cycle after reset or on request, in place of a wide parallel reset.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register
BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read; 0 = reads return stored contents only

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
clear_req  input  1  start a full clear; honoured only in RUN
init_done  output  1  1 = clear complete, file usable
rd_addr_a  input  ADDR_W  read port A address (rs)
rd_data_a  output  DATA_W  read port A data
rd_addr_b  input  ADDR_W  read port B address (rt)
rd_data_b  output  DATA_W  read port B data
we_0  input  1  write enable, port 0
waddr_0  input  ADDR_W  write address, port 0
wdata_0  input  DATA_W  write data, port 0
we_1  input  1  write enable, port 1 (higher priority)
waddr_1  input  ADDR_W  write address, port 1
wdata_1  input  DATA_W  write data, port 1
wr_conflict  output  1  registered pulse: both ports wrote the same effective address in the previous cycle

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Clear FSM has two states, INIT and RUN, with an ADDR_W-bit clear pointer clr_ptr.
- rst = 1 at a clock edge:
  - state <= INIT, clr_ptr <= 0, init_done <= 0, wr_conflict <= 0.
  - Array contents are not reset directly.
  - rst overrides clear_req and all writes. Reset mid-clear restarts clr_ptr at 0.
- INIT, each cycle:
  - mem[clr_ptr] <= 0, then clr_ptr <= clr_ptr + 1.
  - On the cycle clr_ptr == DEPTH-1: state <= RUN and init_done <= 1, effective on the next edge.
  - Clear takes exactly DEPTH cycles after the first edge with rst = 0. For example, with ADDR_W = 5, init_done rises at the 32nd rising edge after rst deasserts.
  - we_0 and we_1 are ignored. rd_data_a and rd_data_b read 0. clear_req is ignored.
- RUN with clear_req = 1: state <= INIT, clr_ptr <= 0, init_done <= 0 at the next edge. Writes in that same cycle are still performed, but are subsequently cleared.
- Writes in RUN:
  - Effective write x means we_x = 1 and not (ZERO_REG and waddr_x == 0).
  - Effective writes update the array on the rising edge.
  - Both effective and waddr_0 == waddr_1: wdata_1 is stored, and wr_conflict <= 1 for one cycle.
  - Otherwise wr_conflict <= 0.
- Reads are combinational from address to data, per port, independently. Priority:
  1. state INIT -> 0
  2. ZERO_REG and addr == 0 -> 0
  3. BYPASS and effective we_1 and waddr_1 == addr -> wdata_1
  4. BYPASS and effective we_0 and waddr_0 == addr -> wdata_0
  5. otherwise mem[addr]
- BYPASS = 0: a read in the same cycle as a write to the same address returns the old value. The new value is visible from the cycle after the edge.
- Widths: no arithmetic on data. clr_ptr wraps naturally, but is never used past DEPTH-1.

Test Plan:
1. Reset and clear: rst = 1 for 2 cycles, then 0; poll init_done -> init_done = 0 for edges 1..31 and 1 from edge 32. rd_data_a = 0 throughout. A write of 0xDEADBEEF to r5 during INIT is lost (r5 reads 0 after init).
2. Basic write/read: in RUN, write r3 = 0x12345678 (port 0) and r7 = 0xCAFEF00D (port 1) in the same cycle; next cycle read A = 3, B = 7 -> 0x12345678 and 0xCAFEF00D. wr_conflict stays 0.
3. Zero register: ZERO_REG = 1, write r0 = 0xFFFFFFFF on both ports -> r0 reads 0, no bypass, wr_conflict stays 0. With ZERO_REG = 0, same stimulus -> r0 reads 0xFFFFFFFF, wr_conflict = 1 for one cycle.
4. Same-address conflict: we_0 = we_1 = 1, waddr = 9, wdata_0 = 0x1, wdata_1 = 0x2 -> r9 = 0x2 after the edge. wr_conflict = 1 for exactly one cycle, then 0.
5. Bypass: BYPASS = 1, write r4 = 0xA5A5A5A5 while rd_addr_a = 4 -> rd_data_a = 0xA5A5A5A5 in the same cycle. BYPASS = 0, r4 previously 0x11 -> rd_data_a = 0x11 that cycle and 0xA5A5A5A5 the next.
6. Mid-run clear, then reset mid-clear:
   - Fill r1..r31 with nonzero values, pulse clear_req -> init_done drops next edge and reads return 0.
   - Assert rst at clear cycle 10 -> clear restarts; init_done returns 32 edges after rst deasserts; all registers read 0.

Source files
------------

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : 2-read / 2-write register file with optional write-to-read
//             bypass, optional hardwired zero entry and a sequential clear.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              init_done,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] waddr_0,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] waddr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              wr_conflict
);

    localparam int                c_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(c_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              init_done_q, init_done_d;
    logic              wr_conflict_q, wr_conflict_d;
    logic [DATA_W-1:0] mem_q [c_DEPTH];

    logic w_eff_0;
    logic w_eff_1;
    logic w_same_addr;
    logic w_run;
    logic w_clr_we;
    logic w_wr_0;
    logic w_wr_1;

    // A write to entry 0 is not a write at all when the zero register is on.
    assign w_eff_0     = we_0 && !((ZERO_REG != 0) && (waddr_0 == '0));
    assign w_eff_1     = we_1 && !((ZERO_REG != 0) && (waddr_1 == '0));
    assign w_same_addr = (waddr_0 == waddr_1);
    assign w_run       = (state_q == ST_RUN);

    always_comb begin
        state_d       = state_q;
        clr_ptr_d     = clr_ptr_q;
        init_done_d   = init_done_q;
        wr_conflict_d = 1'b0;
        w_clr_we      = 1'b0;
        w_wr_0        = 1'b0;
        w_wr_1        = 1'b0;
        case (state_q)
            ST_INIT: begin
                w_clr_we  = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == c_LAST) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Port 1 wins a same-address collision.
                w_wr_0        = w_eff_0 && !(w_eff_1 && w_same_addr);
                w_wr_1        = w_eff_1;
                wr_conflict_d = w_eff_0 && w_eff_1 && w_same_addr;
                if (clear_req) begin
                    state_d     = ST_INIT;
                    clr_ptr_d   = '0;
                    init_done_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            clr_ptr_q     <= '0;
            init_done_q   <= 1'b0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            init_done_q   <= init_done_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Storage has no reset of its own; the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) mem_q[clr_ptr_q] <= '0;
            if (w_wr_0)   mem_q[waddr_0]   <= wdata_0;
            if (w_wr_1)   mem_q[waddr_1]   <= wdata_1;
        end
    end

    // Later assignments take priority: INIT, zero entry, port 1, port 0, array.
    always_comb begin
        rd_data_a = mem_q[rd_addr_a];
        if ((BYPASS != 0) && w_eff_0 && (waddr_0 == rd_addr_a)) rd_data_a = wdata_0;
        if ((BYPASS != 0) && w_eff_1 && (waddr_1 == rd_addr_a)) rd_data_a = wdata_1;
        if ((ZERO_REG != 0) && (rd_addr_a == '0))              rd_data_a = '0;
        if (!w_run)                                             rd_data_a = '0;
    end

    always_comb begin
        rd_data_b = mem_q[rd_addr_b];
        if ((BYPASS != 0) && w_eff_0 && (waddr_0 == rd_addr_b)) rd_data_b = wdata_0;
        if ((BYPASS != 0) && w_eff_1 && (waddr_1 == rd_addr_b)) rd_data_b = wdata_1;
        if ((ZERO_REG != 0) && (rd_addr_b == '0))              rd_data_b = '0;
        if (!w_run)                                             rd_data_b = '0;
    end

    assign init_done   = init_done_q;
    assign wr_conflict = wr_conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : directed bench for regfile_mp; one instance with zero register
//             and bypass, one with both disabled, driven by the same stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_req;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic        we_0, we_1;
    logic [4:0]  waddr_0, waddr_1;
    logic [31:0] wdata_0, wdata_1;

    logic        d_init_done, d_wr_conflict;
    logic [31:0] d_rd_a, d_rd_b;
    logic        x_init_done, x_wr_conflict;
    logic [31:0] x_rd_a, x_rd_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .init_done(d_init_done),
        .rd_addr_a(rd_addr_a), .rd_data_a(d_rd_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(d_rd_b),
        .we_0(we_0), .waddr_0(waddr_0), .wdata_0(wdata_0),
        .we_1(we_1), .waddr_1(waddr_1), .wdata_1(wdata_1),
        .wr_conflict(d_wr_conflict)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_alt (
        .clk(clk), .rst(rst), .clear_req(clear_req), .init_done(x_init_done),
        .rd_addr_a(rd_addr_a), .rd_data_a(x_rd_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(x_rd_b),
        .we_0(we_0), .waddr_0(waddr_0), .wdata_0(wdata_0),
        .we_1(we_1), .waddr_1(waddr_1), .wdata_1(wdata_1),
        .wr_conflict(x_wr_conflict)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // d* = zero-reg/bypass instance, x* = plain instance; c = wr_conflict after the edge.
    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] da;
        logic [31:0] db;
        logic [31:0] xa;
        logic [31:0] xb;
        logic        dc;
        logic        xc;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1'b1, 5'd3, 32'h12345678, 1'b1, 5'd7, 32'hCAFEF00D, 5'd3, 5'd7,
                     32'h12345678, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7,
                     32'h12345678, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd3,
                     32'h0, 32'h12345678, 32'h0, 32'h12345678, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
                     32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 5'd9, 5'd9,
                     32'h2, 32'h2, 32'h0, 32'h0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd7,
                     32'h2, 32'hCAFEF00D, 32'h2, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 5'd4, 32'h11, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4,
                     32'h11, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 5'd4, 5'd3,
                     32'hA5A5A5A5, 32'h12345678, 32'h11, 32'h12345678, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd0,
                     32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, 5'd6, 5'd8,
                     32'h66, 32'h88, 32'h0, 32'h0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd8, 32'h99, 1'b0, 5'd8, 32'hBAD, 5'd8, 5'd6,
                     32'h99, 32'h66, 32'h88, 32'h66, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd31,
                     32'h99, 32'h0, 32'h99, 32'h0, 1'b0, 1'b0};

        rst = 1'b1; clear_req = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0;
        we_0 = 1'b0; waddr_0 = '0; wdata_0 = '0;
        we_1 = 1'b0; waddr_1 = '0; wdata_1 = '0;

        // Reset, then initial clear with a write that must be lost.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_done_d", 32'(d_init_done), 32'h0);
        chk("rst_init_done_x", 32'(x_init_done), 32'h0);
        chk("rst_conflict_d", 32'(d_wr_conflict), 32'h0);
        chk("rst_conflict_x", 32'(x_wr_conflict), 32'h0);
        rst = 1'b0;
        we_0 = 1'b1; waddr_0 = 5'd5; wdata_0 = 32'hDEADBEEF; rd_addr_a = 5'd5;
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk);
            #1;
            chk("init_done_d", 32'(d_init_done), 32'(e == 32));
            chk("init_done_x", 32'(x_init_done), 32'(e == 32));
            if (e < 32) begin
                chk("init_rd_d", d_rd_a, 32'h0);
                chk("init_rd_x", x_rd_a, 32'h0);
            end
        end
        we_0 = 1'b0;
        #1;
        chk("lost_r5_d", d_rd_a, 32'h0);
        chk("lost_r5_x", x_rd_a, 32'h0);

        // Table-driven run-mode vectors.
        for (int i = 0; i < 12; i++) begin
            we_0 = vecs[i].we0; waddr_0 = vecs[i].wa0; wdata_0 = vecs[i].wd0;
            we_1 = vecs[i].we1; waddr_1 = vecs[i].wa1; wdata_1 = vecs[i].wd1;
            rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
            @(negedge clk);
            chk($sformatf("v%0d_rd_a_d", i), d_rd_a, vecs[i].da);
            chk($sformatf("v%0d_rd_b_d", i), d_rd_b, vecs[i].db);
            chk($sformatf("v%0d_rd_a_x", i), x_rd_a, vecs[i].xa);
            chk($sformatf("v%0d_rd_b_x", i), x_rd_b, vecs[i].xb);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_conf_d", i), 32'(d_wr_conflict), 32'(vecs[i].dc));
            chk($sformatf("v%0d_conf_x", i), 32'(x_wr_conflict), 32'(vecs[i].xc));
        end

        // Fill r1..r31, two entries per cycle.
        for (int i = 1; i < 32; i += 2) begin
            we_0 = 1'b1; waddr_0 = 5'(i);     wdata_0 = 32'h1000_0000 | 32'(i);
            we_1 = (i < 31); waddr_1 = 5'(i + 1); wdata_1 = 32'h1000_0000 | 32'(i + 1);
            @(posedge clk);
            #1;
        end
        we_0 = 1'b0; we_1 = 1'b0;
        rd_addr_a = 5'd17; rd_addr_b = 5'd31;
        #1;
        chk("fill_r17_d", d_rd_a, 32'h1000_0011);
        chk("fill_r31_x", x_rd_b, 32'h1000_001F);

        // Clear request with a same-cycle write that is performed then wiped.
        clear_req = 1'b1;
        we_0 = 1'b1; waddr_0 = 5'd20; wdata_0 = 32'hABC; rd_addr_a = 5'd20;
        #1;
        chk("clrreq_byp_d", d_rd_a, 32'hABC);
        chk("clrreq_old_x", x_rd_a, 32'h1000_0014);
        chk("clrreq_done_d", 32'(d_init_done), 32'h1);
        @(posedge clk);
        #1;
        clear_req = 1'b0; we_0 = 1'b0;
        chk("clr_done_d", 32'(d_init_done), 32'h0);
        chk("clr_done_x", 32'(x_init_done), 32'h0);
        chk("clr_rd_a_d", d_rd_a, 32'h0);
        chk("clr_rd_b_x", x_rd_b, 32'h0);

        // Reset in the middle of the clear restarts the pointer.
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk);
            #1;
            chk("reclr_done_d", 32'(d_init_done), 32'(e == 32));
            chk("reclr_done_x", 32'(x_init_done), 32'(e == 32));
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr_a = 5'(a); rd_addr_b = 5'(31 - a);
            #1;
            chk($sformatf("zero_a%0d_d", a), d_rd_a, 32'h0);
            chk($sformatf("zero_b%0d_d", a), d_rd_b, 32'h0);
            chk($sformatf("zero_a%0d_x", a), x_rd_a, 32'h0);
            chk($sformatf("zero_b%0d_x", a), x_rd_b, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
